// File: rtl/divider_pkg.sv
// Shared widths, FSM encoding and operand helpers for the EX-stage divider.
package divider_pkg;

    localparam int DATA_BUS        = 32;
    localparam int DOUBLE_DATA_BUS = 64;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself and reads as 2^31.
    function automatic logic [DATA_BUS-1:0] mag(input logic [DATA_BUS-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring iteration: shift {rem, quot} left, trial-subtract, keep or restore.
module div_step
    import divider_pkg::*;
(
    input  logic [DATA_BUS:0]   i_rem,
    input  logic [DATA_BUS-1:0] i_quot,
    input  logic [DATA_BUS-1:0] i_divisor,
    output logic [DATA_BUS:0]   o_rem,
    output logic [DATA_BUS-1:0] o_quot
);

    logic [DATA_BUS+1:0] w_shift;
    logic [DATA_BUS+1:0] w_diff;

    // The shifted remainder never reaches 2^33, so bit 33 of the difference is the borrow.
    assign w_shift = {i_rem, i_quot[DATA_BUS-1]};
    assign w_diff  = w_shift - {2'b00, i_divisor};

    always_comb begin
        o_rem  = w_shift[DATA_BUS:0];
        o_quot = {i_quot[DATA_BUS-2:0], 1'b0};
        if (!w_diff[DATA_BUS+1]) begin
            o_rem  = w_diff[DATA_BUS:0];
            o_quot = {i_quot[DATA_BUS-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), result = {remainder, quotient}.
module divider
    import divider_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       is_signed,
    input  logic [DATA_BUS-1:0]        dividend,
    input  logic [DATA_BUS-1:0]        divisor,
    input  logic                       cancel,
    output logic                       busy,
    output logic                       done,
    output logic                       div_by_zero,
    output logic [DOUBLE_DATA_BUS-1:0] result
);

    div_state_e          r_state;
    logic [4:0]          r_cnt;
    logic [DATA_BUS:0]   r_rem;
    logic [DATA_BUS-1:0] r_quot;
    logic [DATA_BUS-1:0] r_dvs;
    logic                r_qneg;
    logic                r_rneg;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_BUS:0]   w_next_rem;
    logic [DATA_BUS-1:0] w_next_quot;
    logic [DATA_BUS-1:0] w_q_fix;
    logic [DATA_BUS-1:0] w_r_fix;

    assign w_a_neg = is_signed & dividend[DATA_BUS-1];
    assign w_b_neg = is_signed & divisor[DATA_BUS-1];
    assign w_q_fix = mag(w_next_quot, r_qneg);
    assign w_r_fix = mag(w_next_rem[DATA_BUS-1:0], r_rneg);

    div_step u_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_dvs),
        .o_rem     (w_next_rem),
        .o_quot    (w_next_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DIV_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_dvs       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else if (cancel) begin
            r_state <= DIV_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE, DIV_DONE: begin
                    done    <= 1'b0;
                    r_state <= DIV_IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            // Skip iterating: the answer is fixed by the divide-by-zero convention.
                            r_state     <= DIV_DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            result      <= {dividend, {DATA_BUS{1'b1}}};
                        end else begin
                            r_state     <= DIV_CALC;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            r_quot      <= mag(dividend, w_a_neg);
                            r_dvs       <= mag(divisor, w_b_neg);
                            r_rem       <= '0;
                            r_cnt       <= '0;
                            r_qneg      <= w_a_neg ^ w_b_neg;
                            r_rneg      <= w_a_neg;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem  <= w_next_rem;
                    r_quot <= w_next_quot;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= DIV_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= {w_r_fix, w_q_fix};
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Randomized + directed self-checking bench for divider against an arithmetic reference.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating division on wide integers; remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output int cyc, output int bcnt);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        bcnt  = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), (b == 32'd0) ? 64'd1 : 64'd33);
        check({tag, " result"}, result, ref_div(s, a, b));
        check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, b == 32'd0});
    endtask

    task automatic expect_no_done(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check({tag, " no done"}, 64'(seen), 64'd0);
    endtask

    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    initial begin
        int          cyc, bcnt;
        logic [63:0] prev;
        logic [31:0] a, b;
        logic        s;

        rst = 1'b1; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        check("reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, "divu 100/7", cyc, bcnt);
        check("divu 100/7 const", result, 64'h0000_0002_0000_000E);
        check("divu 100/7 busy cycles", 64'(bcnt), 64'd32);
        @(negedge clk);
        check("done single pulse", {63'd0, done}, 64'd0);

        run_op(1'b1, -32'sd7, 32'd2, "div -7/2", cyc, bcnt);
        check("div -7/2 const", result, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        run_op(1'b1, 32'd7, -32'sd2, "div 7/-2", cyc, bcnt);
        check("div 7/-2 const", result, 64'h0000_0001_FFFF_FFFD);
        @(negedge clk);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow", cyc, bcnt);
        check("div overflow const", result, 64'h0000_0000_8000_0000);
        @(negedge clk);
        run_op(1'b0, 32'h1234, 32'd0, "divu by zero", cyc, bcnt);
        check("divu by zero const", result, 64'h0000_1234_FFFF_FFFF);
        @(negedge clk);
        check("dz done single pulse", {63'd0, done}, 64'd0);

        // Second start issued in the DONE cycle of the first.
        run_op(1'b0, 32'd5, 32'd3, "b2b first", cyc, bcnt);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "b2b second", cyc, bcnt);
        check("b2b second const", result, 64'h0000_0000_FFFF_FFFF);
        check("b2b clears dz", {63'd0, div_by_zero}, 64'd0);

        @(negedge clk);
        prev = result;
        is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", {63'd0, busy}, 64'd0);
        check("cancel result kept", result, prev);
        expect_no_done("cancel", 40);

        start = 1'b1; cancel = 1'b1; dividend = 32'd77; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start+cancel busy", {63'd0, busy}, 64'd0);
        expect_no_done("start+cancel", 40);
        check("start+cancel result kept", result, prev);

        is_signed = 1'b0; dividend = 32'd12345; divisor = 32'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("async reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_no_done("after reset", 40);
        run_op(1'b0, 32'd12345, 32'd17, "post-reset", cyc, bcnt);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = edge_vals[$urandom_range(0, 5)]; b = edge_vals[$urandom_range(0, 5)]; end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(s, a, b, $sformatf("rand%0d", i), cyc, bcnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
